// File: rtl/alu_exec_mc_pkg.sv
// Shared ALU definitions: ALUCtrl encodings, execute-unit FSM states and
// the multiplier step legality check.
package alu_defs;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_SRAI = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  typedef enum logic {IDLE, MUL_RUN} state_e;

  function automatic bit mul_step_legal(input int unsigned width, input int unsigned step);
    return ((step == 1) || (step == 2) || (step == 4)) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/alu_exec_mc_if.sv
// Operand/result handshake bundle between the EX stage control and the ALU.
// master = upstream issuer, slave = alu_exec_mc.
interface alu_exec_mc_if #(parameter int WIDTH = 32);

  logic             valid_i;
  logic             ready_o;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (output valid_i, ALUCtrl_i, data1_i, data2_i,
                  input  ready_o, valid_o, result_o, zero_o);

  modport slave  (input  valid_i, ALUCtrl_i, data1_i, data2_i,
                  output ready_o, valid_o, result_o, zero_o);

endinterface

// File: rtl/alu_exec_mc_mul_iter.sv
// Iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
// done_o flags the final step; acc_nxt_o then carries the finished product.
module mul_iter
  import alu_defs::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] acc_nxt_o
);

  localparam int N  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(N + 1);

  if (!mul_step_legal(WIDTH, MUL_STEP)) begin : g_bad_step
    $error("mul_iter: MUL_STEP must be 1, 2 or 4 and divide WIDTH");
  end

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, pp, acc_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (b_q[i]) pp = pp + (a_q << i);
    end
    acc_nxt = acc_q + pp;
  end

  assign acc_nxt_o = acc_nxt;
  assign done_o    = (cnt_q == CW'(1));

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = CW'(N);
    end else if (cnt_q != '0) begin
      a_d   = a_q << MUL_STEP;
      b_d   = b_q >> MUL_STEP;
      acc_d = acc_nxt;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops answer one cycle after accept,
// MUL holds ready_o low for WIDTH/MUL_STEP cycles. flush_i drops everything.
module alu_exec_mc
  import alu_defs::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  alu_exec_mc_if.slave bus
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d, zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, mul_res;
  logic             accept, mul_start, mul_abort, mul_done;
  logic [4:0]       sh;

  assign sh     = bus.data2_i[4:0];
  assign accept = bus.valid_i & (state_q == IDLE) & ~flush_i;

  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl_i)
      ALU_AND:  alu_res = bus.data1_i & bus.data2_i;
      ALU_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
      ALU_ADD:  alu_res = bus.data1_i + bus.data2_i;
      ALU_SUB:  alu_res = bus.data1_i - bus.data2_i;
      ALU_SLL:  alu_res = bus.data1_i << sh;
      ALU_SRAI: alu_res = WIDTH'($signed(bus.data1_i) >>> sh);
      default:  alu_res = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .abort_i   (mul_abort),
    .a_i       (bus.data1_i),
    .b_i       (bus.data2_i),
    .done_o    (mul_done),
    .acc_nxt_o (mul_res)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    mul_start = 1'b0;
    mul_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL_RUN;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        // Flush beats a completing multiply: no pulse, old result kept.
        if (flush_i) begin
          mul_abort = 1'b1;
          state_d   = IDLE;
        end else if (mul_done) begin
          result_d = mul_res;
          zero_d   = (mul_res == '0);
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed plus randomized bench for alu_exec_mc (MUL_STEP=1 and MUL_STEP=4).
module tb_alu_exec_mc;
  import alu_defs::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush1, flush4;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  alu_exec_mc_if #(.WIDTH(32)) if1 ();
  alu_exec_mc_if #(.WIDTH(32)) if4 ();

  alu_exec_mc #(.WIDTH(32), .MUL_STEP(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush1), .bus(if1.slave));
  alu_exec_mc #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush4), .bus(if4.slave));

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      3'b000: return a & b;
      3'b001: return a ^ b;
      3'b010: return a + b;
      3'b110: return a - b;
      3'b111: return a << sh;
      3'b100: return a[31] ? ~((~a) >> sh) : (a >> sh);
      3'b011: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if1.valid_i = 1'b1; if1.ALUCtrl_i = op; if1.data1_i = a; if1.data2_i = b;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int lat;
    drive1(op, a, b);
    step();
    if1.valid_i = 1'b0;
    lat = 1;
    while (if1.valid_o !== 1'b1 && lat < 40) begin step(); lat++; end
    chk({tag, "_lat"}, lat, (op == ALU_MUL) ? 33 : 1);
    chk({tag, "_res"}, if1.result_o, exp);
    chk({tag, "_zero"}, if1.zero_o, (exp == 0));
    step();
    chk({tag, "_single_pulse"}, if1.valid_o, 1'b0);
    last_exp = exp;
  endtask

  task automatic do_mul4(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    logic [31:0] exp;
    exp = model(ALU_MUL, a, b);
    if4.valid_i = 1'b1; if4.ALUCtrl_i = ALU_MUL; if4.data1_i = a; if4.data2_i = b;
    step();
    if4.valid_i = 1'b0;
    lat = 1;
    while (if4.valid_o !== 1'b1 && lat < 40) begin step(); lat++; end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_res"}, if4.result_o, exp);
    step();
  endtask

  task automatic no_pulse_window(input string tag);
    int bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (if1.valid_o !== 1'b0) bad++;
      step();
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int bad;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst_n = 1'b0; flush1 = 1'b0; flush4 = 1'b0;
    if1.valid_i = 1'b0; if1.ALUCtrl_i = 3'b000; if1.data1_i = '0; if1.data2_i = '0;
    if4.valid_i = 1'b0; if4.ALUCtrl_i = 3'b000; if4.data1_i = '0; if4.data2_i = '0;
    step(); step();
    chk("rst_ready", if1.ready_o, 1'b1);
    chk("rst_valid", if1.valid_o, 1'b0);
    chk("rst_result", if1.result_o, 32'd0);
    chk("rst_zero", if1.zero_o, 1'b1);
    rst_n = 1'b1;
    step();

    // ADD then SUB back to back
    drive1(ALU_ADD, 32'd5, 32'd7);
    step();
    drive1(ALU_SUB, 32'd7, 32'd7);
    chk("add_valid", if1.valid_o, 1'b1);
    chk("add_res", if1.result_o, 32'd12);
    chk("add_zero", if1.zero_o, 1'b0);
    step();
    if1.valid_i = 1'b0;
    chk("sub_valid", if1.valid_o, 1'b1);
    chk("sub_res", if1.result_o, 32'd0);
    chk("sub_zero", if1.zero_o, 1'b1);
    step();
    chk("b2b_idle", if1.valid_o, 1'b0);

    do_op(ALU_SRAI, 32'h8000_0010, 32'd4, 32'hF800_0001, "srai");
    do_op(ALU_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, "sll");
    do_op(ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, "xor");
    do_op(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, "and");
    do_op(3'b101, 32'd3, 32'd4, 32'd0, "undef");

    // MUL with an ADD held upstream during the stall
    drive1(ALU_MUL, 32'hFFFF_FFFF, 32'd3);
    step();
    drive1(ALU_ADD, 32'h0000_1234, 32'h0000_1111);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (if1.ready_o !== 1'b0 || if1.valid_o !== 1'b0) bad++;
      step();
    end
    chk("mul_stall_cycles", bad, 0);
    chk("mul_valid", if1.valid_o, 1'b1);
    chk("mul_res", if1.result_o, 32'hFFFF_FFFD);
    chk("mul_ready_back", if1.ready_o, 1'b1);
    step();
    if1.valid_i = 1'b0;
    chk("held_add_valid", if1.valid_o, 1'b1);
    chk("held_add_res", if1.result_o, 32'h0000_2345);
    step();
    chk("held_add_single", if1.valid_o, 1'b0);
    last_exp = 32'h0000_2345;

    do_mul4(32'hFFFF_FFFF, 32'd3, "mul4_dir");

    // flush during cycle T+10 of a MUL
    drive1(ALU_MUL, $urandom, $urandom);
    step();
    if1.valid_i = 1'b0;
    repeat (9) step();
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    chk("flush_ready", if1.ready_o, 1'b1);
    chk("flush_hold_res", if1.result_o, last_exp);
    no_pulse_window("flush_no_pulse");

    // flush on the completing cycle
    drive1(ALU_MUL, 32'd6, 32'd7);
    step();
    if1.valid_i = 1'b0;
    repeat (31) step();
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    chk("flush_done_valid", if1.valid_o, 1'b0);
    chk("flush_done_ready", if1.ready_o, 1'b1);
    chk("flush_done_res", if1.result_o, last_exp);
    no_pulse_window("flush_done_no_pulse");

    // flush with valid_i in IDLE
    drive1(ALU_ADD, 32'd9, 32'd9);
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    if1.valid_i = 1'b0;
    chk("flush_idle_valid", if1.valid_o, 1'b0);
    chk("flush_idle_res", if1.result_o, last_exp);
    step();
    chk("flush_idle_late", if1.valid_o, 1'b0);

    // reset in the middle of a MUL
    do_op(ALU_ADD, 32'd1, 32'd1, 32'd2, "pre_rst");
    drive1(ALU_MUL, 32'd11, 32'd13);
    step();
    if1.valid_i = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_res", if1.result_o, 32'd0);
    chk("midrst_zero", if1.zero_o, 1'b1);
    chk("midrst_valid", if1.valid_o, 1'b0);
    chk("midrst_ready", if1.ready_o, 1'b1);
    no_pulse_window("midrst_no_pulse");

    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      do_op(op, a, b, model(op, a, b), "rand");
    end
    for (int n = 0; n < 4; n++) begin
      do_mul4($urandom, $urandom, "mul4_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
- Multi-cycle ALU execute unit; consumes the 3-bit ALUCtrl code produced by the ALU control decoder and the two operands.
- Single-cycle ops return registered results one cycle after acceptance. MUL runs an iterative shift-add sequence and backpressures the pipeline through ready_o.
- Sits in the EX stage; its result feeds the EX/MEM register and the hazard/stall logic.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_STEP, 1, multiplier bits consumed per MUL cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- flush_i  in  1  abort any in-flight op, drop the accept in the same cycle
- valid_i  in  1  operands and ALUCtrl_i valid
- ready_o  out  1  unit can accept; accept = valid_i & ready_o & ~flush_i
- ALUCtrl_i  in  3  operation: AND 000, XOR 001, ADD 010, SUB 110, SLL 111, MUL 011, SRAI 100; 101 undefined
- data1_i  in  WIDTH  operand A
- data2_i  in  WIDTH  operand B (shift amount = data2_i[4:0])
- valid_o  out  1  one-cycle pulse; result_o and zero_o valid
- result_o  out  WIDTH  registered result; holds its last value between pulses
- zero_o  out  1  registered (result == 0), updated with result_o

Behaviour:
- Reset (rst_i==0 at posedge): state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1, counter=0. Reset mid-MUL discards the operation; no valid_o pulse follows.
- States: IDLE, MUL_RUN.
- IDLE, ready_o=1:
  - Accept of a non-MUL op at edge T: result registered, valid_o=1 in cycle T+1. State stays IDLE, so back-to-back accepts give one result per cycle.
  - Accept of MUL: latch A, B, acc=0, cnt=WIDTH/MUL_STEP; go to MUL_RUN; ready_o=0 from the next cycle.
- MUL_RUN, ready_o=0:
  - Each cycle: acc += A * B[MUL_STEP-1:0] (low WIDTH bits only); A <<= MUL_STEP; B >>= MUL_STEP; cnt--.
  - When cnt reaches 0: result_o=acc, valid_o=1, state returns to IDLE, ready_o=1 in the same cycle.
  - With N = WIDTH/MUL_STEP, an accept at edge T gives valid_o at T+N+1. Default N=32, so valid_o at T+33.
- valid_i while ready_o=0 is ignored; upstream holds operands (stall).
- Arithmetic:
  - ADD and SUB are two's-complement modulo 2^WIDTH; no overflow flag.
  - SLL: A << B[4:0].
  - SRAI: arithmetic right shift, A >>> B[4:0], sign-filled.
  - MUL returns the low WIDTH bits of the product; the result is identical for signed and unsigned operands.
  - Code 101: result 0, valid_o still pulses, zero_o=1.
- flush_i:
  - In MUL_RUN: return to IDLE next cycle with no valid_o; result_o and zero_o keep their old values.
  - In IDLE with valid_i: no accept, no valid_o next cycle.
  - Flush and completion in the same cycle (cnt hitting 0): flush wins, no pulse.
- valid_o never asserts in two consecutive cycles for one accept. It is 0 in every cycle without a completed accept.

Decomposition:
- Package alu_defs: the ALUCtrl code constants (shared with the ALU control decoder), the state enum {IDLE, MUL_RUN}, and the MUL_STEP legality check.
- One sub-module, mul_iter: holds the shift-add datapath (A/B/acc registers, counter) with start/abort/done. The top level keeps the FSM, single-cycle ops, handshake, and output registers.

Test Plan:
- Reset, then ADD 5 + 7 accepted -> next cycle valid_o=1, result_o=12, zero_o=0. Then SUB 7 - 7 back-to-back -> following cycle result_o=0, zero_o=1.
- SRAI data1=0x80000010, data2=4 -> result_o=0xF8000001. SLL 0x1, shift 31 -> 0x80000000. XOR 0xFF00FF00 ^ 0x0F0F0F0F -> 0xF00FF00F. AND of the same -> 0x0F000F00.
- MUL 0xFFFFFFFF * 3 accepted at T (MUL_STEP=1) -> ready_o=0 for T+1..T+32, valid_o only at T+33, result_o=0xFFFFFFFD. Repeat with MUL_STEP=4 -> valid_o at T+9.
- valid_i held with ADD operands during a MUL -> ignored until ready_o=1, then accepted. Results arrive in order: MUL result, then ADD result one cycle later.
- flush_i asserted in cycle T+10 of a MUL -> no valid_o, ready_o=1 at T+11, result_o keeps the previous value. rst_i=0 mid-MUL -> result_o=0, zero_o=1, no pulse.
- ALUCtrl_i=101 with data 3, 4 -> valid_o pulse, result_o=0, zero_o=1. flush_i and valid_i in the same IDLE cycle -> no pulse next cycle.
